fwd_hazard_unit: RTL
====================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised operand-bypass and hazard unit for the pipelined core. Sits at the EX operand muxes.
//  Per source operand, forwards the youngest matching in-flight result from DEPTH tracked stages.
//  Also forwards from the WB port and from a HIST-entry retirement history buffer.
//  Stalls on not-yet-ready producers (load-use) and flags stalls that never resolve.
// PARAMETERS
//  XLEN      32  datapath width
//  NUM_SRC   2   source operands resolved per cycle
//  DEPTH     2   in-flight producer stages tracked; index 0 = youngest (EX/MEM)
//  HIST      2   retired writes held after WB; covers read-before-write register file
//  MAX_STALL 8   consecutive stall cycles before stall_timeout is raised
// PORTS
//  clk           in   1                 core clock
//  rst_n         in   1                 async active-low reset
//  flush         in   1                 pipeline flush; clears stall counter only
//  id_valid      in   1                 consumer instruction present this cycle
//  rs            in   NUM_SRC*5         source register indices
//  rs_data       in   NUM_SRC*XLEN      register file read data
//  stg_wen       in   DEPTH             stage will write rd
//  stg_rd        in   DEPTH*5           stage destination register
//  stg_ready     in   DEPTH             stage result valid (0 = load awaiting memory)
//  stg_data      in   DEPTH*XLEN        stage result
//  wb_wen        in   1                 register file write this cycle
//  wb_rd         in   5                 write-back register index
//  wb_data       in   XLEN              write-back data
//  fwd_data      out  NUM_SRC*XLEN      resolved operands
//  fwd_hit       out  NUM_SRC           operand came from a bypass, not rs_data
//  stall         out  1                 hold ID/EX, insert bubble
//  stall_timeout out  1                 sticky; stall lasted >= MAX_STALL cycles
//  fwd_count     out  32                FWD_STATS_EN only; otherwise tied 0
//  stall_cycles  out  32                FWD_STATS_EN only; otherwise tied 0
// BEHAVIOUR
//  - Operand resolution is combinational, with 0-cycle latency. Each source is resolved independently.
//    - rs==0: always use rs_data, fwd_hit=0, and never stall, even when a stage targets x0.
//    - Priority order: stg 0..DEPTH-1, then WB, then history newest..oldest, then rs_data. First match wins.
//    - Stage match means stg_wen[i] && stg_rd[i]==rs.
//      - If stg_ready[i]: operand = stg_data[i].
//      - Else: the source is hazarded. Older entries are NOT consulted.
//    - A WB match requires wb_wen && wb_rd==rs. History match requires entry valid && rd==rs.
//  - stall = id_valid && any source hazarded && !flush. It is forced 0 while rst_n=0.
//  - History buffer: a HIST-deep shift register.
//    - On a clk edge with wb_wen && wb_rd!=0, push {rd,data} at the head. The oldest entry drops.
//    - A pushed entry is visible from the next cycle.
//    - Duplicate rd entries are allowed; the newest wins by priority.
//    - flush does NOT clear the history, because its contents are retired state.
//  - Stall counter: 0..MAX_STALL, saturating.
//    - While stall=1 it increments each cycle. On a cycle with stall=0, or on flush, it resets to 0.
//    - stall_timeout sets on the edge where the counter reaches MAX_STALL. It clears only on reset.
//  - Async reset:
//    - All history entries invalid, counter 0, stall_timeout 0, stats 0.
//    - Reset asserted mid-stall aborts the stall immediately.
// CONFIGURATION
//  FWD_STATS_EN defined:
//    - fwd_count adds the number of sources with fwd_hit=1 each cycle where id_valid && !stall.
//    - stall_cycles increments on every stall=1 cycle.
//    - Both counters wrap at 2^32.
//  Undefined: the counters are not built and both ports drive 0. No other behaviour changes.
// STRUCTURE
//  fwd_pkg: reg_idx_t (logic [4:0]); REG_ZERO; hist_entry_t struct {valid, rd, data};
//    fwd_result_t struct {data, hit, hazard}.
//  Sub-module fwd_src_select: combinational priority search for one source. Instantiated NUM_SRC times.
//    The top level owns the history, the counter, and stall/stats.
// TESTING
//  1. rs[0]=2; stg0 wen rd=2 ready data=124; stg1 wen rd=2 data=18 -> fwd_data[0]=124, fwd_hit[0]=1.
//  2. rs[0]=0; stg0 wen rd=0 data=124; rs_data[0]=250 -> fwd_data[0]=250, fwd_hit=0, stall=0.
//  3. Load-use, id_valid=1: rs[1]=5; stg0 rd=5 ready=0; stg1 rd=5 ready data=7 -> stall=1.
//     Next cycle ready=1 data=0xDEAD -> stall=0, fwd_data[1]=0xDEAD.
//  4. History: wb rd=7 data=0x55 at t; at t+1 no stage match, rs=7, rs_data=0 -> 0x55.
//     After HIST more pushes to other regs -> rs_data.
//  5. Hold the hazard of test 3 -> stall_timeout=1 after the MAX_STALL-th stall edge, sticky.
//     flush -> stall=0, counter 0, timeout still 1.
//  6. rst_n=0 mid-stall -> stall=0, history empty (test 4 read returns rs_data), timeout=0, stats=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage operand bypass / hazard unit.
package fwd_pkg;

    localparam int unsigned FWD_XLEN = 32;
    localparam int unsigned REG_W    = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        reg_idx_t            rd;
        logic [FWD_XLEN-1:0] data;
    } hist_entry_t;

    typedef struct packed {
        logic [FWD_XLEN-1:0] data;
        logic                hit;
        logic                hazard;
    } fwd_result_t;

    function automatic logic rd_match(input logic wen, input reg_idx_t rd, input reg_idx_t rs);
        return wen && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Combinational priority search for one source operand:
// stages youngest..oldest, then WB, then history newest..oldest, then register file.
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned HIST  = 2
) (
    input  reg_idx_t                    rs,
    input  logic [FWD_XLEN-1:0]         rs_data,
    input  logic [DEPTH-1:0]            stg_wen,
    input  logic [DEPTH*REG_W-1:0]      stg_rd,
    input  logic [DEPTH-1:0]            stg_ready,
    input  logic [DEPTH*FWD_XLEN-1:0]   stg_data,
    input  logic                        wb_wen,
    input  reg_idx_t                    wb_rd,
    input  logic [FWD_XLEN-1:0]         wb_data,
    input  hist_entry_t [HIST-1:0]      hist,
    output fwd_result_t                 result_c
);

    logic found;

    // First match wins; a not-ready stage match blocks everything older.
    always_comb begin
        result_c = '{data: rs_data, hit: 1'b0, hazard: 1'b0};
        found    = (rs == REG_ZERO);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && rd_match(stg_wen[i], stg_rd[i*REG_W +: REG_W], rs)) begin
                found = 1'b1;
                if (stg_ready[i]) begin
                    result_c.data = stg_data[i*FWD_XLEN +: FWD_XLEN];
                    result_c.hit  = 1'b1;
                end else begin
                    result_c.hazard = 1'b1;
                end
            end
        end

        if (!found && rd_match(wb_wen, wb_rd, rs)) begin
            found         = 1'b1;
            result_c.data = wb_data;
            result_c.hit  = 1'b1;
        end

        for (int unsigned h = 0; h < HIST; h++) begin
            if (!found && rd_match(hist[h].valid, hist[h].rd, rs)) begin
                found         = 1'b1;
                result_c.data = hist[h].data;
                result_c.hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass and load-use hazard unit at the EX operand muxes.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN      = FWD_XLEN,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned HIST      = 2,
    parameter int unsigned MAX_STALL = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_W-1:0]  rs,
    input  logic [NUM_SRC*XLEN-1:0]   rs_data,
    input  logic [DEPTH-1:0]          stg_wen,
    input  logic [DEPTH*REG_W-1:0]    stg_rd,
    input  logic [DEPTH-1:0]          stg_ready,
    input  logic [DEPTH*XLEN-1:0]     stg_data,
    input  logic                      wb_wen,
    input  logic [REG_W-1:0]          wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    output logic [NUM_SRC*XLEN-1:0]   fwd_data,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic                      stall,
    output logic                      stall_timeout,
    output logic [31:0]               fwd_count,
    output logic [31:0]               stall_cycles
);

    localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

    // The history/result structs are sized by the package datapath width.
    if (XLEN != FWD_XLEN) begin : g_xlen_check
        $error("fwd_hazard_unit: XLEN must equal fwd_pkg::FWD_XLEN");
    end

    hist_entry_t [HIST-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic                   stall_timeout_q, stall_timeout_d;
    fwd_result_t            res [NUM_SRC];
    logic                   any_hazard;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_select #(
            .DEPTH (DEPTH),
            .HIST  (HIST)
        ) u_sel (
            .rs        (rs[s*REG_W +: REG_W]),
            .rs_data   (rs_data[s*XLEN +: XLEN]),
            .stg_wen   (stg_wen),
            .stg_rd    (stg_rd),
            .stg_ready (stg_ready),
            .stg_data  (stg_data),
            .wb_wen    (wb_wen),
            .wb_rd     (wb_rd),
            .wb_data   (wb_data),
            .hist      (hist_q),
            .result_c  (res[s])
        );
        assign fwd_data[s*XLEN +: XLEN] = res[s].data;
        assign fwd_hit[s]               = res[s].hit;
    end

    always_comb begin
        any_hazard = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            any_hazard = any_hazard | res[s].hazard;
        end
    end

    // Gated by rst_n so an in-progress stall drops the moment reset asserts.
    assign stall = rst_n && id_valid && any_hazard && !flush;

    // Retired-write history: shift in at the head, oldest falls off. x0 writes are not kept.
    always_comb begin
        hist_d = hist_q;
        if (wb_wen && (wb_rd != REG_ZERO)) begin
            for (int h = int'(HIST) - 1; h > 0; h--) begin
                hist_d[h] = hist_q[h-1];
            end
            hist_d[0] = '{valid: 1'b1, rd: wb_rd, data: wb_data};
        end
    end

    // Saturating consecutive-stall counter; flush is already folded into stall.
    always_comb begin
        stall_cnt_d     = '0;
        stall_timeout_d = stall_timeout_q;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == CNT_W'(MAX_STALL)) ? stall_cnt_q
                                                             : stall_cnt_q + CNT_W'(1);
        end
        if (stall_cnt_d == CNT_W'(MAX_STALL)) begin
            stall_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q          <= '0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            hist_q          <= hist_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_timeout = stall_timeout_q;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_count_q, fwd_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        fwd_count_d    = fwd_count_q;
        stall_cycles_d = stall_cycles_q;
        if (id_valid && !stall) begin
            fwd_count_d = fwd_count_q + 32'($countones(fwd_hit));
        end
        if (stall) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            fwd_count_q    <= fwd_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign fwd_count    = fwd_count_q;
    assign stall_cycles = stall_cycles_q;
`else
    assign fwd_count    = '0;
    assign stall_cycles = '0;
`endif

endmodule
